// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage: PC, imem addressing and {pc, instr} FIFO to decode
module fetch_queue #(
  parameter int N     = 64,
  parameter int AW    = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [AW-1:0]              imem_addr,
  input  logic [31:0]                imem_q,
  input  logic                       redirect_valid,
  input  logic [N-1:0]               redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [N-1:0]               out_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [N-1:0]  pc_q, pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [N-1:0]  pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic pop;
  logic full;
  logic push;

  assign pop  = out_valid & out_ready;
  assign full = (count_q == CW'(DEPTH));
  // A slot freed by decode this cycle can be refilled on the same edge.
  assign push = ~redirect_valid & (~full | pop);

  // imem reads combinationally from the current PC word address.
  assign imem_addr = pc_q[AW+1:2];

  // Head of queue, forced to zero when nothing is held.
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
  assign count     = count_q;

  // Next-state for PC, pointers and occupancy; redirect overrides everything.
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & ~N'(3);
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + N'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care when not counted, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= pc_q;
      instr_mem[wr_ptr_q] <= imem_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  count;

  logic [31:0] imem [64];

  int checks;
  int errors;

  fetch_queue #(.N(64), .AW(6), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb imem_q = imem[imem_addr];

  task automatic do_reset(input logic rdy);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = rdy;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL reset_pc got %h want 0", out_pc); end
    checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h want 0", out_instr); end
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'hf8000001; exp_i[1] = 32'hf8008002; exp_i[2] = 32'hf8000203;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", i, out_valid); end
      checks++; if (out_pc !== 64'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, 4 * i); end
      checks++; if (out_instr !== exp_i[i]) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", i, out_instr, exp_i[i]); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d want 1", i, count); end
    end
  endtask

  task automatic test_full_stall();
    do_reset(1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i <= 4) begin
        checks++; if (count !== 3'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
      end else begin
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count[%0d] got %0d want 4", i, count); end
        checks++; if (imem_addr !== 6'd4) begin errors++; $display("FAIL full_addr[%0d] got %0d want 4", i, imem_addr); end
        checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL full_head[%0d] got %h want 0", i, out_pc); end
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (out_pc !== 64'(4 * i)) begin errors++; $display("FAIL drain_pc[%0d] got %h want %h", i, out_pc, 4 * i); end
      if (i == 3) begin
        checks++; if (out_instr !== 32'h8b050083) begin errors++; $display("FAIL drain_instr12 got %h want 8b050083", out_instr); end
      end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL drain_count[%0d] got %0d want 4", i, count); end
      @(negedge clk);
    end
  endtask

  task automatic redirect_to(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    redirect_to(64'h74);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %0b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL redir_count got %0d want 0", count); end
    checks++; if (imem_addr !== 6'd29) begin errors++; $display("FAIL redir_addr got %0d want 29", imem_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL redir_valid2 got %0b want 1", out_valid); end
    checks++; if (out_pc !== 64'h74) begin errors++; $display("FAIL redir_pc got %h want 74", out_pc); end
    checks++; if (out_instr !== 32'hb4000040) begin errors++; $display("FAIL redir_instr got %h want b4000040", out_instr); end
  endtask

  task automatic test_misaligned();
    redirect_to(64'hBE);
    checks++; if (imem_addr !== 6'd47) begin errors++; $display("FAIL mis_addr got %0d want 47", imem_addr); end
    @(negedge clk);
    checks++; if (out_pc !== 64'hBC) begin errors++; $display("FAIL mis_pc got %h want bc", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL mis_instr got %h want 0", out_instr); end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h74;
    @(negedge clk);
    redirect_pc    = 64'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 6'd16) begin errors++; $display("FAIL b2b_addr got %0d want 16", imem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got %0b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_pc !== 64'h40) begin errors++; $display("FAIL b2b_pc got %h want 40", out_pc); end
    checks++; if (out_instr !== 32'h10000010) begin errors++; $display("FAIL b2b_instr got %h want 10000010", out_instr); end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_pc [3];
    logic [5:0]  exp_a  [3];
    exp_pc[0] = 64'hF8; exp_pc[1] = 64'hFC; exp_pc[2] = 64'h100;
    exp_a[0] = 6'd63; exp_a[1] = 6'd0; exp_a[2] = 6'd1;
    redirect_to(64'hF8);
    checks++; if (imem_addr !== 6'd62) begin errors++; $display("FAIL wrap_addr0 got %0d want 62", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_pc !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc[%0d] got %h want %h", i, out_pc, exp_pc[i]); end
      checks++; if (imem_addr !== exp_a[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i, imem_addr, exp_a[i]); end
    end
    checks++; if (out_instr !== 32'hf8000001) begin errors++; $display("FAIL wrap_instr got %h want f8000001", out_instr); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ar_full got %0d want 4", count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %0b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_count got %0d want 0", count); end
    checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL ar_pc got %h want 0", out_pc); end
    checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL ar_instr got %h want 0", out_instr); end
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL ar_addr got %0d want 0", imem_addr); end
    @(negedge clk);
    out_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (out_pc !== 64'(4 * i)) begin errors++; $display("FAIL ar_restart[%0d] got %h want %h", i, out_pc, 4 * i); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h10000000 | 32'(i);
    imem[0]  = 32'hf8000001;
    imem[1]  = 32'hf8008002;
    imem[2]  = 32'hf8000203;
    imem[3]  = 32'h8b050083;
    imem[29] = 32'hb4000040;
    imem[47] = 32'h00000000;
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    test_reset();
    test_stream();
    test_full_stall();
    test_redirect();
    test_misaligned();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
